// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus slave: FSM states, request
// opcodes, the error-data pattern and the receive-length helper.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RX   = 3'd1,
        EXEC = 3'd2,
        WAIT = 3'd3,
        TX   = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Returned on reads of indices beyond the implemented depth; slice to width.
    localparam logic [63:0] ERR_DATA = {64{1'b1}};

    function automatic int rx_len(input int addr_bits, input int data_bits);
        return (addr_bits > data_bits) ? addr_bits : data_bits;
    endfunction

endpackage

// File: rtl/serial_mem_slave_ram.sv
// Single-port word memory with one-cycle registered read and write enable.
// Contents are deliberately not reset so they survive a bus reset.
module serial_mem_slave_ram
    import serial_bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port and registered read port share the one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/serial_mem_slave.sv
// Serial bus memory slave: shifts in address/data, decodes slave ID and index,
// serves writes and reads from the local RAM and shifts read data back out.
module serial_mem_slave
    import serial_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int SLAVE_ID_WIDTH = 2,
    parameter int SLAVE_ID       = 0,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    input  logic master_ready,
    output logic slave_ready,
    output logic slave_valid,
    input  logic rx_address,
    input  logic rx_data,
    output logic tx_data,
    output logic rx_done,
    output logic slave_tx_done,
    output logic addr_err
);

    localparam int IDX_W  = ADDR_WIDTH - SLAVE_ID_WIDTH;
    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int RX_MAX = rx_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W  = $clog2(RX_MAX + 1);

    state_t                  state_r;
    state_t                  state_s;
    op_t                     op_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_sh_r;
    logic [DATA_WIDTH-1:0]   data_sh_r;
    logic [DATA_WIDTH-1:0]   tx_sh_r;
    logic                    oor_r;
    logic                    req_err_r;

    logic [SLAVE_ID_WIDTH-1:0] id_s;
    logic [IDX_W-1:0]          idx_s;
    logic                      id_match_s;
    logic                      idx_oor_s;
    logic                      accept_s;
    logic                      bad_req_s;
    logic                      rx_last_s;
    logic                      tx_last_s;
    logic                      ram_we_s;
    logic [DATA_WIDTH-1:0]     ram_rdata_s;

    assign id_s       = addr_sh_r[ADDR_WIDTH-1 -: SLAVE_ID_WIDTH];
    assign idx_s      = addr_sh_r[IDX_W-1:0];
    assign id_match_s = (id_s == SLAVE_ID_WIDTH'(SLAVE_ID));
    assign idx_oor_s  = (32'(idx_s) >= 32'(MEM_DEPTH));
    assign accept_s   = master_valid & (read_en ^ write_en);
    assign bad_req_s  = master_valid & ~(read_en ^ write_en);
    assign rx_last_s  = (op_r == OP_WRITE) ? (cnt_r == CNT_W'(RX_MAX - 1))
                                           : (cnt_r == CNT_W'(ADDR_WIDTH - 1));
    assign tx_last_s  = (cnt_r == CNT_W'(DATA_WIDTH - 1));
    // Reset in the EXEC cycle must still suppress the pending write.
    assign ram_we_s   = (state_r == EXEC) & (op_r == OP_WRITE) & id_match_s
                        & ~idx_oor_s & ~reset;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RX;
                else          state_s = IDLE;
            end
            RX: begin
                if (rx_last_s) state_s = EXEC;
                else           state_s = RX;
            end
            EXEC: begin
                if (id_match_s && (op_r == OP_READ)) state_s = WAIT;
                else                                 state_s = IDLE;
            end
            WAIT: begin
                if (master_ready) state_s = TX;
                else              state_s = WAIT;
            end
            TX: begin
                if (tx_last_s) state_s = IDLE;
                else           state_s = TX;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, shifters, counters and latched request attributes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            op_r      <= OP_READ;
            cnt_r     <= '0;
            addr_sh_r <= '0;
            data_sh_r <= '0;
            tx_sh_r   <= '0;
            oor_r     <= 1'b0;
            req_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            req_err_r <= (state_r == IDLE) & bad_req_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (accept_s) begin
                        op_r <= write_en ? OP_WRITE : OP_READ;
                    end
                end
                RX: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (32'(cnt_r) < ADDR_WIDTH) begin
                        addr_sh_r <= {addr_sh_r[ADDR_WIDTH-2:0], rx_address};
                    end
                    if ((op_r == OP_WRITE) && (32'(cnt_r) < DATA_WIDTH)) begin
                        data_sh_r <= {data_sh_r[DATA_WIDTH-2:0], rx_data};
                    end
                end
                EXEC: begin
                    oor_r <= idx_oor_s;
                end
                WAIT: begin
                    if (master_ready) begin
                        tx_sh_r <= oor_r ? ERR_DATA[DATA_WIDTH-1:0] : ram_rdata_s;
                        cnt_r   <= '0;
                    end
                end
                TX: begin
                    tx_sh_r <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign slave_ready   = (state_r == IDLE);
    assign slave_valid   = (state_r == WAIT);
    assign tx_data       = (state_r == TX) & tx_sh_r[DATA_WIDTH-1];
    assign rx_done       = (state_r == EXEC) & id_match_s;
    assign slave_tx_done = (state_r == TX) & tx_last_s;
    assign addr_err      = req_err_r | ((state_r == EXEC) & id_match_s & idx_oor_s);

    serial_mem_slave_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (idx_s[RAM_AW-1:0]),
        .wdata (data_sh_r),
        .rdata (ram_rdata_s)
    );

endmodule
